uc_fsm: RTL and testbench
=========================

# uc_fsm

Multi-cycle control unit for the 10-bit-PC microcontroller datapath. Consumes the datapath's `Opcode` and `z` outputs and drives its control inputs (`s_inc`, `s_inm`, `we3`, `wez`, `s_skip`, `Op`) plus a PC-enable, sequencing each instruction through FETCH/DECODE/EXEC. Adds free-run/single-step execution, a sticky HALT and a retired-instruction counter for debug.

## Interface
Parameters:
- `ICNT_W`, 16, width of the retired-instruction counter

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Opcode`  in  6  instruction[15:10] from the datapath
- `z`  in  1  zero flag from the datapath
- `run`  in  1  level; 1 = free-running execution
- `step`  in  1  one-cycle pulse; executes exactly one instruction when `run`=0 and state is IDLE
- `s_inc`  out  1  PC mux select: 1 = PC+inc, 0 = jump target
- `s_skip`  out  1  increment select: 0 = +1, 1 = +2
- `s_inm`  out  1  write-data select: 1 = immediate, 0 = ALU
- `we3`  out  1  register-file write enable
- `wez`  out  1  zero-flag write enable
- `Op`  out  3  ALU operation
- `pc_en`  out  1  PC register load enable (datapath PC gains an enable input)
- `halted`  out  1  HALT executed
- `busy`  out  1  state is FETCH, DECODE or EXEC
- `icount`  out  ICNT_W  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT. Reset -> IDLE.
- IDLE -> FETCH when `run`=1 or `step`=1; else stay.
- FETCH -> DECODE (program memory read cycle).
- DECODE: latch `Opcode` into `op_q`, `z` into `z_q`; -> EXEC.
- EXEC: decode `op_q`, assert controls, `pc_en`=1 (except HALT); -> HALT if HALT, else FETCH if `run`=1, else IDLE.
- HALT: all enables 0; left only by reset.
- Decode of `op_q` (in EXEC only):
  - `000ooo`: ALU op, `Op`=ooo, `we3`=1, `wez`=1, `s_inm`=0, `s_inc`=1.
  - `001000` LI: `we3`=1, `s_inm`=1, `wez`=0, `s_inc`=1.
  - `010000` J: `s_inc`=0.
  - `010001` JZ: `s_inc`=~`z_q`.
  - `010010` JNZ: `s_inc`=`z_q`.
  - `010011` SKZ: `s_inc`=1, `s_skip`=`z_q`.
  - `111111` HALT: `pc_en`=0, no writes.
  - all other codes: NOP (`pc_en`=1, `s_inc`=1, no writes).
- Outside EXEC: `we3`=`wez`=`pc_en`=`s_inm`=`s_skip`=0, `s_inc`=1, `Op`=000.
- `icount` increments by 1 on each EXEC whose opcode is not HALT; saturates at all-ones.

## Timing
- Reset values: state IDLE, all enables 0, `s_inc`=1, `Op`=000, `halted`=0, `busy`=0, `icount`=0, `op_q`=0, `z_q`=0.
- Controls are Moore outputs of state and `op_q`/`z_q`; glitch-free for the whole EXEC cycle.
- Latency: 3 cycles per instruction in free run; PC and register file update on the rising edge ending EXEC.
- `step` honoured only in IDLE with `run`=0; pulses in any other state are dropped, not queued.
- `run` falling mid-instruction: current instruction completes, then IDLE.
- `run` and `step` both 1 in IDLE: behaves as run.
- `halted` is 1 from the cycle after the HALT EXEC until reset; `busy`=0 in HALT.
- Reset asserted mid-instruction: immediate return to IDLE, no write completes in that cycle.

## Structure
- Package `uc_pkg`: state enum, opcode constants (`OP_LI`, `OP_J`, `OP_JZ`, `OP_JNZ`, `OP_SKZ`, `OP_HALT`), ALU class prefix `3'b000`.
- One combinational sub-module `uc_decode` (`op_q`, `z_q` -> control vector); FSM, latches and counter in `uc_fsm`.

## Test plan
- Reset release, `run`=0, no step: state IDLE, all enables 0, `s_inc`=1, `icount`=0 for 20 cycles.
- `run`=1, Opcode=`000010`: `we3`=`wez`=`pc_en`=1, `Op`=010 exactly on cycles 3, 6, 9; `icount`=3 after 9 cycles.
- JZ with `z`=1 then `z`=0: `s_inc`=0 then 1 in EXEC; SKZ with `z`=1: `s_skip`=1, `s_inc`=1.
- `run`=0, single `step` pulse: exactly one EXEC, back to IDLE, `icount`+1; `step` during DECODE ignored.
- HALT opcode: EXEC with `pc_en`=0, `halted`=1 next cycle, stays despite `run`/`step`; `icount` unchanged; reset clears.
- Reset low during EXEC of LI: `we3` drops asynchronously, state IDLE, `icount` unchanged.

Source files
------------

// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uc_pkg
// Description : Shared types and opcode constants for the microcontroller
//               control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package uc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [5:0] OP_LI   = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_SKZ  = 6'b010011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Upper opcode bits that select the register-register ALU class.
    localparam logic [2:0] c_alu_cls = 3'b000;

    typedef struct packed {
        logic       s_inc;
        logic       s_skip;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic       pc_en;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t c_ctrl_idle = '{
        s_inc: 1'b1, s_skip: 1'b0, s_inm: 1'b0, we3: 1'b0,
        wez: 1'b0, pc_en: 1'b0, alu_op: 3'b000
    };

endpackage
`default_nettype wire

// File: rtl/uc_decode.sv
`default_nettype none
// ============================================================================
// Module      : uc_decode
// Description : Combinational opcode decoder producing the EXEC-cycle
//               datapath control vector.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic       i_z,
    output ctrl_t      o_ctrl
);

    always_comb begin
        // Unlisted opcodes fall through as NOP: advance PC by one, no writes.
        o_ctrl = '{
            s_inc: 1'b1, s_skip: 1'b0, s_inm: 1'b0, we3: 1'b0,
            wez: 1'b0, pc_en: 1'b1, alu_op: 3'b000
        };
        if (i_op[5:3] == c_alu_cls) begin
            o_ctrl.we3    = 1'b1;
            o_ctrl.wez    = 1'b1;
            o_ctrl.alu_op = i_op[2:0];
        end else begin
            case (i_op)
                OP_LI: begin
                    o_ctrl.we3   = 1'b1;
                    o_ctrl.s_inm = 1'b1;
                end
                OP_J:    o_ctrl.s_inc  = 1'b0;
                OP_JZ:   o_ctrl.s_inc  = ~i_z;
                OP_JNZ:  o_ctrl.s_inc  = i_z;
                OP_SKZ:  o_ctrl.s_skip = i_z;
                OP_HALT: o_ctrl.pc_en  = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uc_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uc_fsm
// Description : Multi-cycle FETCH/DECODE/EXEC control unit with run/step,
//               sticky halt and saturating retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_fsm
    import uc_pkg::*;
#(
    parameter int ICNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        Opcode,
    input  logic              z,
    input  logic              run,
    input  logic              step,
    output logic              s_inc,
    output logic              s_skip,
    output logic              s_inm,
    output logic              we3,
    output logic              wez,
    output logic [2:0]        Op,
    output logic              pc_en,
    output logic              halted,
    output logic              busy,
    output logic [ICNT_W-1:0] icount
);

    state_t            r_state;
    logic [5:0]        r_op_q;
    logic              r_z_q;
    logic              r_halted;
    logic              r_busy;
    logic [ICNT_W-1:0] r_icount;
    ctrl_t             w_dec;
    ctrl_t             w_ctrl;

    uc_decode u_decode (
        .i_op   (r_op_q),
        .i_z    (r_z_q),
        .o_ctrl (w_dec)
    );

    // Controls depend only on registers, so they hold steady for all of EXEC
    // and collapse to idle the moment reset drives the state to IDLE.
    assign w_ctrl = (r_state == ST_EXEC) ? w_dec : c_ctrl_idle;

    assign s_inc  = w_ctrl.s_inc;
    assign s_skip = w_ctrl.s_skip;
    assign s_inm  = w_ctrl.s_inm;
    assign we3    = w_ctrl.we3;
    assign wez    = w_ctrl.wez;
    assign Op     = w_ctrl.alu_op;
    assign pc_en  = w_ctrl.pc_en;
    assign halted = r_halted;
    assign busy   = r_busy;
    assign icount = r_icount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op_q   <= 6'b000000;
            r_z_q    <= 1'b0;
            r_halted <= 1'b0;
            r_busy   <= 1'b0;
            r_icount <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run || step) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_op_q  <= Opcode;
                    r_z_q   <= z;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_op_q == OP_HALT) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        if (r_icount != '1) begin
                            r_icount <= r_icount + ICNT_W'(1);
                        end
                        r_state <= run ? ST_FETCH : ST_IDLE;
                        r_busy  <= run;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uc_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_fsm
// Description : Scoreboard bench for uc_fsm driven by a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_fsm;

    localparam int ICW     = 5;
    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_DEC   = 2;
    localparam int S_EXEC  = 3;
    localparam int S_HALT  = 4;

    logic           clk    = 1'b0;
    logic           reset  = 1'b0;
    logic           run    = 1'b0;
    logic           step   = 1'b0;
    logic           z      = 1'b0;
    logic [5:0]     Opcode = 6'd0;
    logic           s_inc, s_skip, s_inm, we3, wez, pc_en, halted, busy;
    logic [2:0]     Op;
    logic [ICW-1:0] icount;

    uc_fsm #(.ICNT_W(ICW)) dut (
        .clk    (clk),
        .reset  (reset),
        .Opcode (Opcode),
        .z      (z),
        .run    (run),
        .step   (step),
        .s_inc  (s_inc),
        .s_skip (s_skip),
        .s_inm  (s_inm),
        .we3    (we3),
        .wez    (wez),
        .Op     (Op),
        .pc_en  (pc_en),
        .halted (halted),
        .busy   (busy),
        .icount (icount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]     ctrl;   // {s_inc,s_skip,s_inm,we3,wez,pc_en,Op}
        logic [1:0]     stat;   // {halted,busy}
        logic [ICW-1:0] icnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    int             m_st;
    logic [5:0]     m_op;
    logic           m_z;
    logic [ICW-1:0] m_ic;
    logic           m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic logic [8:0] exp_ctrl(input int st, input logic [5:0] op, input logic zq);
        if (st != S_EXEC)         return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        if (op[5:3] == 3'b000)    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, op[2:0]};
        case (op)
            6'b001000: return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000};
            6'b010000: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
            6'b010001: return {~zq,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
            6'b010010: return {zq,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
            6'b010011: return {1'b1, zq,   1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
            6'b111111: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
            default:   return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        endcase
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.ctrl = exp_ctrl(m_st, m_op, m_z);
        e.stat = {m_halt, (m_st == S_FETCH || m_st == S_DEC || m_st == S_EXEC)};
        e.icnt = m_ic;
        return e;
    endfunction

    task automatic model_reset();
        m_st   = S_IDLE;
        m_op   = 6'd0;
        m_z    = 1'b0;
        m_ic   = '0;
        m_halt = 1'b0;
    endtask

    task automatic model_step();
        case (m_st)
            S_IDLE:  if (run || step) m_st = S_FETCH;
            S_FETCH: m_st = S_DEC;
            S_DEC: begin
                m_op = Opcode;
                m_z  = z;
                m_st = S_EXEC;
            end
            S_EXEC: begin
                if (m_op == 6'b111111) begin
                    m_st   = S_HALT;
                    m_halt = 1'b1;
                end else begin
                    if (m_ic != {ICW{1'b1}}) m_ic = m_ic + ICW'(1);
                    m_st = run ? S_FETCH : S_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: advance the model on the edge, queue what the DUT must show.
    task automatic cyc();
        @(posedge clk);
        if (reset) model_step();
        sb_q.push_back(model_exp());
        #1;
    endtask

    task automatic wait_state(input int s);
        for (int n = 0; n < 10 && m_st != s; n++) cyc();
    endtask

    task automatic drain();
        run = 1'b0;
        wait_state(S_IDLE);
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        sb_q.delete();
        sb_q.push_back(model_exp());
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ctrl",   32'({s_inc, s_skip, s_inm, we3, wez, pc_en, Op}), 32'(e.ctrl));
            chk("status", 32'({halted, busy}), 32'(e.stat));
            chk("icount", 32'(icount), 32'(e.icnt));
        end
    end

    // {opcode, z, step held during DECODE}
    logic [7:0] tbl [11] = '{
        {6'b010001, 1'b1, 1'b0}, {6'b010001, 1'b0, 1'b1}, {6'b010011, 1'b1, 1'b0},
        {6'b010011, 1'b0, 1'b0}, {6'b010000, 1'b0, 1'b0}, {6'b010010, 1'b1, 1'b1},
        {6'b010010, 1'b0, 1'b0}, {6'b001000, 1'b0, 1'b0}, {6'b101010, 1'b1, 1'b0},
        {6'b000111, 1'b0, 1'b0}, {6'b000101, 1'b1, 1'b0}
    };

    initial begin
        logic [7:0] ent;
        model_reset();
        sb_q.push_back(model_exp());
        repeat (2) cyc();
        reset = 1'b1;

        repeat (20) cyc();

        Opcode = 6'b000010;
        run    = 1'b1;
        repeat (9) cyc();
        drain();

        // Single steps; operands change after DECODE to prove they were latched.
        for (int i = 0; i < 11; i++) begin
            ent    = tbl[i];
            Opcode = ent[7:2];
            z      = ent[1];
            step   = 1'b1;
            cyc();
            step   = 1'b0;
            cyc();
            step   = ent[0];
            cyc();
            step   = 1'b0;
            z      = ~ent[1];
            Opcode = 6'b111111;
            repeat (2) cyc();
        end

        // run and step together, then run drops mid-instruction.
        Opcode = 6'b000011;
        run    = 1'b1;
        step   = 1'b1;
        cyc();
        step   = 1'b0;
        cyc();
        run    = 1'b0;
        repeat (4) cyc();

        // HALT is sticky against run and step until reset.
        Opcode = 6'b111111;
        run    = 1'b1;
        wait_state(S_HALT);
        run    = 1'b0;
        step   = 1'b1;
        cyc();
        step   = 1'b0;
        run    = 1'b1;
        repeat (4) cyc();
        step   = 1'b1;
        cyc();
        step   = 1'b0;
        run    = 1'b0;
        cyc();
        do_reset();
        repeat (3) cyc();

        // Reset asserted in the middle of an LI EXEC.
        Opcode = 6'b001000;
        run    = 1'b1;
        wait_state(S_EXEC);
        chk("li_we3_exec", 32'(we3), 32'(1));
        run   = 1'b0;
        reset = 1'b0;
        #1;
        chk("li_we3_async", 32'(we3), 32'(0));
        chk("li_inm_async", 32'(s_inm), 32'(0));
        model_reset();
        sb_q.delete();
        sb_q.push_back(model_exp());
        cyc();
        reset = 1'b1;
        repeat (3) cyc();

        // Long free run to drive the counter into saturation.
        Opcode = 6'b000001;
        run    = 1'b1;
        repeat (120) cyc();
        drain();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
